// File: rtl/fetch_pkg.sv
// Shared constants for the fetch-stage sequencer: FSM encodings, NOP word, default reset PC.
package fetch_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 2'd0;
  localparam fetch_state_t S_REQ  = 2'd1;
  localparam fetch_state_t S_WAIT = 2'd2;
  localparam fetch_state_t S_HOLD = 2'd3;

endpackage

// File: rtl/fetch_redir_arb.sv
// Redirect arbitration: a trap always wins over a branch in the same cycle.
module fetch_redir_arb #(
  parameter int XLEN = 64
) (
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target,
  output logic            o_redir,
  output logic [XLEN-1:0] o_redir_target
);

  assign o_redir        = i_trap_valid | i_br_valid;
  assign o_redir_target = i_trap_valid ? i_trap_target : i_br_target;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one I-memory request in flight,
// and buffers a single instruction for decode.
//
//   state  | meaning
//   S_IDLE | one settling cycle after reset
//   S_REQ  | request presented at pc, waiting for accept
//   S_WAIT | request accepted, waiting for the response pulse
//   S_HOLD | instruction buffered, waiting for decode to take it
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            id_ready
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [31:0]     r_if_instr;

  logic            w_redir;
  logic [XLEN-1:0] w_target;

  fetch_redir_arb #(.XLEN(XLEN)) u_arb (
    .i_trap_valid   (trap_valid),
    .i_trap_target  (trap_target),
    .i_br_valid     (br_valid),
    .i_br_target    (br_target),
    .o_redir        (w_redir),
    .o_redir_target (w_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP_INSTR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redir) r_pc <= w_target;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_redir) r_pc <= w_target;
          // A redirect on the accept cycle means the accepted request is already stale.
          if (imem_req_ready) begin
            r_kill  <= w_redir;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_kill <= 1'b0;
            if (w_redir) r_pc <= w_target;
            if (r_kill || w_redir) begin
              r_state <= S_REQ;
            end else begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_instr <= imem_resp_data;
              r_state    <= S_HOLD;
            end
          end else if (w_redir) begin
            r_pc   <= w_target;
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          // Redirect takes precedence over pc+4 even when decode accepts this cycle.
          if (w_redir || id_ready) begin
            r_if_valid <= 1'b0;
            r_pc       <= w_redir ? w_target : r_pc + XLEN'(4);
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;

endmodule
